// File: rtl/pwr_fault_logger.sv
// rtl/pwr_fault_logger.sv - debounced sticky fault logger for the power sequencer with BMC clear handshake and blink LED
module pwr_fault_logger #(
    parameter int DEB_CYCLES = 4,
    parameter int CLK_PER_MS = 2000,
    parameter int BLINK_MS   = 250
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [6:0] iFlt_N,
    input  logic [3:0] iSeq_State,
    input  logic       iClear_Req,
    output logic [6:0] oFault_Sticky,
    output logic [3:0] oFirst_Fault_Code,
    output logic [3:0] oFirst_Fault_State,
    output logic [7:0] oFault_Count,
    output logic       oClear_Ack,
    output logic       oFault_Any_N,
    output logic       oFault_LED
);

    localparam logic [3:0] DEB = 4'(DEB_CYCLES);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [MW-1:0] MS_MAX  = MW'(BLINK_MS - 1);

    typedef enum logic [1:0] {S_EMPTY, S_LOGGED, S_CLEAR} state_t;

    state_t       r_state;
    logic [3:0]   r_deb_cnt [7];
    logic [6:0]   r_qual;
    logic [6:0]   r_qual_d;
    logic         r_req_m;
    logic         r_req_s;
    logic [6:0]   r_sticky;
    logic [3:0]   r_code;
    logic [3:0]   r_fstate;
    logic [7:0]   r_count;
    logic         r_ack;
    logic         r_any_n;
    logic         r_led;
    logic [PW-1:0] r_pre;
    logic [MW-1:0] r_ms;

    logic [6:0]   w_rise;
    logic         w_suppress;
    logic [6:0]   w_sticky_nxt;
    logic         w_tick;

    // Lowest index wins when several flags qualify on the same edge.
    function automatic logic [3:0] first_code(input logic [6:0] q);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 6; i >= 0; i--) begin
            if (q[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 7; i++) r_deb_cnt[i] <= 4'd0;
            r_qual   <= 7'd0;
            r_qual_d <= 7'd0;
        end else begin
            r_qual_d <= r_qual;
            for (int i = 0; i < 7; i++) begin
                if (iFlt_N[i]) begin
                    r_deb_cnt[i] <= 4'd0;
                    r_qual[i]    <= 1'b0;
                end else if (r_deb_cnt[i] != DEB) begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
                    if (r_deb_cnt[i] + 4'd1 == DEB) r_qual[i] <= 1'b1;
                end
            end
        end
    end

    assign w_rise       = r_qual & ~r_qual_d;
    // Entering, holding or leaving S_CLEAR all keep the logged fields at zero.
    assign w_suppress   = (r_state == S_CLEAR) || r_req_s;
    assign w_sticky_nxt = w_suppress ? 7'd0 : (r_sticky | r_qual);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state  <= S_EMPTY;
            r_req_m  <= 1'b0;
            r_req_s  <= 1'b0;
            r_sticky <= 7'd0;
            r_any_n  <= 1'b1;
            r_code   <= 4'd0;
            r_fstate <= 4'd0;
            r_count  <= 8'd0;
            r_ack    <= 1'b0;
        end else begin
            r_req_m  <= iClear_Req;
            r_req_s  <= r_req_m;
            r_sticky <= w_sticky_nxt;
            r_any_n  <= ~|w_sticky_nxt;
            case (r_state)
                S_EMPTY, S_LOGGED: begin
                    if (r_req_s) begin
                        r_state  <= S_CLEAR;
                        r_ack    <= 1'b1;
                        r_code   <= 4'd0;
                        r_fstate <= 4'd0;
                        r_count  <= 8'd0;
                    end else begin
                        if (r_state == S_EMPTY && |r_qual) begin
                            r_code   <= first_code(r_qual);
                            r_fstate <= iSeq_State;
                            r_state  <= S_LOGGED;
                        end
                        if (|w_rise && r_count != 8'hFF) r_count <= r_count + 8'd1;
                    end
                end
                S_CLEAR: begin
                    if (!r_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign w_tick = (r_pre == PRE_MAX);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_pre <= '0;
            r_ms  <= '0;
            r_led <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (r_sticky == 7'd0) begin
                r_ms  <= '0;
                r_led <= 1'b0;
            end else if (w_tick) begin
                if (r_ms == MS_MAX) begin
                    r_ms  <= '0;
                    r_led <= ~r_led;
                end else begin
                    r_ms <= r_ms + MW'(1);
                end
            end
        end
    end

    assign oFault_Sticky      = r_sticky;
    assign oFirst_Fault_Code  = r_code;
    assign oFirst_Fault_State = r_fstate;
    assign oFault_Count       = r_count;
    assign oClear_Ack         = r_ack;
    assign oFault_Any_N       = r_any_n;
    assign oFault_LED         = r_led;

endmodule

// File: tb/tb_pwr_fault_logger.sv
// tb/tb_pwr_fault_logger.sv - directed table-driven bench for pwr_fault_logger
`timescale 1ns/1ps
module tb_pwr_fault_logger;

    logic       iClk;
    logic       iRst_n;
    logic [6:0] iFlt_N;
    logic [3:0] iSeq_State;
    logic       iClear_Req;
    logic [6:0] oFault_Sticky;
    logic [3:0] oFirst_Fault_Code;
    logic [3:0] oFirst_Fault_State;
    logic [7:0] oFault_Count;
    logic       oClear_Ack;
    logic       oFault_Any_N;
    logic       oFault_LED;

    int checks = 0;
    int errors = 0;

    pwr_fault_logger #(.DEB_CYCLES(4), .CLK_PER_MS(2), .BLINK_MS(3)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iFlt_N(iFlt_N), .iSeq_State(iSeq_State),
        .iClear_Req(iClear_Req), .oFault_Sticky(oFault_Sticky),
        .oFirst_Fault_Code(oFirst_Fault_Code), .oFirst_Fault_State(oFirst_Fault_State),
        .oFault_Count(oFault_Count), .oClear_Ack(oClear_Ack),
        .oFault_Any_N(oFault_Any_N), .oFault_LED(oFault_LED)
    );

    initial iClk = 1'b0;
    always #250 iClk = ~iClk;

    typedef struct {
        logic [6:0] flt;
        logic [3:0] seq;
        logic       clr;
        int         n;
        logic [6:0] sticky;
        logic [3:0] code;
        logic [3:0] fst;
        logic [7:0] cnt;
        logic       ack;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic chk_fields(input string tag, input logic [6:0] s, input logic [3:0] c,
                              input logic [3:0] f, input logic [7:0] k, input logic a);
        chk({tag, " sticky"}, oFault_Sticky, s);
        chk({tag, " code"}, oFirst_Fault_Code, c);
        chk({tag, " fstate"}, oFirst_Fault_State, f);
        chk({tag, " count"}, oFault_Count, k);
        chk({tag, " ack"}, oClear_Ack, a);
        chk({tag, " any_n"}, oFault_Any_N, (s == 7'd0) ? 1 : 0);
    endtask

    task automatic wait_toggle(output int cyc);
        logic p;
        p = oFault_LED;
        cyc = 0;
        do begin
            @(posedge iClk);
            #1;
            cyc++;
        end while (oFault_LED == p && cyc < 50);
    endtask

    initial begin
        int cyc;
        iRst_n = 1'b0; iFlt_N = 7'h7F; iSeq_State = 4'h0; iClear_Req = 1'b0;
        tick(3);
        chk_fields("reset", 7'h00, 4'h0, 4'h0, 8'h00, 1'b0);
        chk("reset led", oFault_LED, 0);
        iRst_n = 1'b1;

        //            flt    seq  clr  n   sticky code fst  cnt  ack
        vecs.push_back('{7'h7F, 4'h0, 1'b0, 100, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h7D, 4'h5, 1'b0,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h7F, 4'h5, 1'b0,   1, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h7D, 4'h5, 1'b0,   4, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h7D, 4'h5, 1'b0,   1, 7'h02, 4'h2, 4'h5, 8'd1, 1'b0});
        vecs.push_back('{7'h7D, 4'h9, 1'b0,  10, 7'h02, 4'h2, 4'h5, 8'd1, 1'b0});
        vecs.push_back('{7'h7D, 4'h9, 1'b1,   2, 7'h02, 4'h2, 4'h5, 8'd1, 1'b0});
        vecs.push_back('{7'h7D, 4'h9, 1'b1,   1, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7D, 4'h9, 1'b1,   5, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7D, 4'h7, 1'b0,   1, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7D, 4'h7, 1'b0,   1, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7D, 4'h7, 1'b0,   1, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h7D, 4'h7, 1'b0,   1, 7'h02, 4'h2, 4'h7, 8'd0, 1'b0});
        vecs.push_back('{7'h7F, 4'h7, 1'b1,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7F, 4'h7, 1'b0,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h6B, 4'h3, 1'b0,   5, 7'h14, 4'h3, 4'h3, 8'd1, 1'b0});
        vecs.push_back('{7'h2B, 4'h8, 1'b0,   5, 7'h54, 4'h3, 4'h3, 8'd2, 1'b0});
        vecs.push_back('{7'h7F, 4'h8, 1'b0,   5, 7'h54, 4'h3, 4'h3, 8'd2, 1'b0});
        vecs.push_back('{7'h7F, 4'h8, 1'b1,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7F, 4'h8, 1'b0,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        // Fault qualifies on the same edge the clear request takes effect.
        vecs.push_back('{7'h7E, 4'h8, 1'b0,   2, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});
        vecs.push_back('{7'h7E, 4'h8, 1'b1,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b1});
        vecs.push_back('{7'h7F, 4'h8, 1'b0,   3, 7'h00, 4'h0, 4'h0, 8'd0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            iFlt_N = vecs[i].flt; iSeq_State = vecs[i].seq; iClear_Req = vecs[i].clr;
            tick(vecs[i].n);
            chk_fields($sformatf("vec%0d", i), vecs[i].sticky, vecs[i].code,
                       vecs[i].fst, vecs[i].cnt, vecs[i].ack);
        end

        // Reset in the middle of a clear handshake.
        iClear_Req = 1'b1;
        tick(3);
        chk("mid ack before rst", oClear_Ack, 1);
        iRst_n = 1'b0;
        #1;
        chk("mid ack in rst", oClear_Ack, 0);
        tick(2);
        iRst_n = 1'b1;
        tick(2);
        chk("mid ack after 2", oClear_Ack, 0);
        tick(1);
        chk("mid ack after 3", oClear_Ack, 1);
        iClear_Req = 1'b0;
        tick(3);
        chk("mid ack release", oClear_Ack, 0);

        // Count saturation.
        iSeq_State = 4'hA;
        for (int k = 0; k < 300; k++) begin
            iFlt_N = 7'h7E; tick(4);
            iFlt_N = 7'h7F; tick(1);
        end
        chk_fields("sat", 7'h01, 4'h1, 4'hA, 8'd255, 1'b0);
        iFlt_N = 7'h7E; tick(4);
        iFlt_N = 7'h7F; tick(1);
        chk("sat hold", oFault_Count, 255);

        // LED blink period and clear.
        wait_toggle(cyc);
        chk("led first toggle seen", (cyc < 50) ? 1 : 0, 1);
        wait_toggle(cyc);
        chk("led period a", cyc, 6);
        wait_toggle(cyc);
        chk("led period b", cyc, 6);
        iClear_Req = 1'b1;
        tick(3);
        chk("led clr sticky", oFault_Sticky, 0);
        tick(1);
        chk("led off", oFault_LED, 0);
        tick(6);
        chk("led stays off", oFault_LED, 0);
        iClear_Req = 1'b0;
        tick(3);
        chk("final ack", oClear_Ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
